// File: rtl/pid_output_limiter.sv
// Output clamp for a PID/first-order controller stage: limits a single-precision value
// to [YMIN, YMAX] with three-cycle step latency and reports saturation for anti-windup.
module pid_output_limiter #(
    parameter int                SINGLE = 32,
    parameter logic [SINGLE-1:0] YMAX   = 32'h3f800000,
    parameter logic [SINGLE-1:0] YMIN   = 32'hbf800000,
    parameter int                CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              rst_user,
    input  logic              sta,
    input  logic [SINGLE-1:0] x,
    output logic [SINGLE-1:0] y,
    output logic              done_sig,
    output logic              sat_hi,
    output logic              sat_lo,
    output logic              nan_err,
    output logic              ovr_err,
    output logic [CNT_W-1:0]  sat_count
);

    localparam logic [SINGLE-1:0] SIGN_BIT = {1'b1, {(SINGLE-1){1'b0}}};

    // -0 collapses onto +0 so both map to the same key and y never shows a negative zero.
    function automatic logic [SINGLE-1:0] norm_f(input logic [SINGLE-1:0] v);
        return (v == SIGN_BIT) ? '0 : v;
    endfunction

    // Flipping negatives and setting the sign of positives makes unsigned order match float order.
    function automatic logic [SINGLE-1:0] key_f(input logic [SINGLE-1:0] v);
        return v[SINGLE-1] ? ~v : (v | SIGN_BIT);
    endfunction

    function automatic logic is_nan_f(input logic [SINGLE-1:0] v);
        return (v[30:23] == 8'hff) && (v[22:0] != '0);
    endfunction

    localparam logic [SINGLE-1:0] KEY_MAX = key_f(norm_f(YMAX));
    localparam logic [SINGLE-1:0] KEY_MIN = key_f(norm_f(YMIN));

    typedef enum logic [1:0] {IDLE, CAP, CMP, OUT} state_t;

    state_t            state_q, state_d;
    logic [SINGLE-1:0] x_q;
    logic [SINGLE-1:0] key_x;
    logic              gt_q, lt_q, nan_q;
    logic [SINGLE-1:0] y_q;
    logic              done_q, hi_q, lo_q, nan_err_q, ovr_q;
    logic [CNT_W-1:0]  cnt_q;
    logic              accept;
    logic              busy;

    assign accept = sta && ((state_q == IDLE) || (state_q == OUT));
    assign busy   = (state_q == CAP) || (state_q == CMP);
    assign key_x  = key_f(x_q);

    // NOTE: sequential state is only ever written with <= so every register samples
    // pre-edge values regardless of the order of statements or processes.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
        end else if (rst_user) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // NOTE: state_d gets its default before the case so no path leaves it unassigned,
    // which would otherwise infer a latch.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (sta) state_d = CAP;
            CAP:     state_d = CMP;
            CMP:     state_d = OUT;
            OUT:     state_d = sta ? CAP : IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            x_q       <= '0;
            gt_q      <= 1'b0;
            lt_q      <= 1'b0;
            nan_q     <= 1'b0;
            y_q       <= '0;
            done_q    <= 1'b0;
            hi_q      <= 1'b0;
            lo_q      <= 1'b0;
            nan_err_q <= 1'b0;
            ovr_q     <= 1'b0;
            cnt_q     <= '0;
        end else if (rst_user) begin
            x_q       <= '0;
            gt_q      <= 1'b0;
            lt_q      <= 1'b0;
            nan_q     <= 1'b0;
            y_q       <= '0;
            done_q    <= 1'b0;
            hi_q      <= 1'b0;
            lo_q      <= 1'b0;
            nan_err_q <= 1'b0;
            ovr_q     <= 1'b0;
            cnt_q     <= '0;
        end else begin
            if (accept) begin
                x_q <= norm_f(x);
            end
            if (state_q == CAP) begin
                gt_q  <= key_x > KEY_MAX;
                lt_q  <= key_x < KEY_MIN;
                nan_q <= is_nan_f(x_q);
            end
            done_q <= (state_q == CMP);
            if (state_q == CMP) begin
                if (nan_q) begin
                    nan_err_q <= 1'b1;
                end else begin
                    hi_q <= gt_q;
                    lo_q <= lt_q;
                    y_q  <= gt_q ? YMAX : (lt_q ? YMIN : x_q);
                    if ((gt_q || lt_q) && (cnt_q != '1)) begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
            end
            if (sta && busy) begin
                ovr_q <= 1'b1;
            end
        end
    end

    assign y         = y_q;
    assign done_sig  = done_q;
    assign sat_hi    = hi_q;
    assign sat_lo    = lo_q;
    assign nan_err   = nan_err_q;
    assign ovr_err   = ovr_q;
    assign sat_count = cnt_q;

endmodule

// File: tb/tb_pid_output_limiter.sv
// Scoreboard bench for pid_output_limiter: stimulus pushes expected step results derived
// from real-valued float comparisons; a negedge monitor pops them on every done_sig.
module tb_pid_output_limiter;

    localparam logic [31:0] YMAX = 32'h3f800000;
    localparam logic [31:0] YMIN = 32'hbf800000;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        rst_user = 1'b0;
    logic        sta = 1'b0;
    logic [31:0] x = '0;
    logic [31:0] y, y2;
    logic        done_sig, sat_hi, sat_lo, nan_err, ovr_err;
    logic        done2, hi2, lo2, nan2, ovr2;
    logic [15:0] sat_count;
    logic [1:0]  sat_count2;

    pid_output_limiter dut (
        .clk(clk), .rst(rst), .rst_user(rst_user), .sta(sta), .x(x),
        .y(y), .done_sig(done_sig), .sat_hi(sat_hi), .sat_lo(sat_lo),
        .nan_err(nan_err), .ovr_err(ovr_err), .sat_count(sat_count)
    );

    pid_output_limiter #(.CNT_W(2)) dut2 (
        .clk(clk), .rst(rst), .rst_user(rst_user), .sta(sta), .x(x),
        .y(y2), .done_sig(done2), .sat_hi(hi2), .sat_lo(lo2),
        .nan_err(nan2), .ovr_err(ovr2), .sat_count(sat_count2)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [31:0] y;
        logic        hi;
        logic        lo;
        logic        nan;
        logic [15:0] cnt;
        logic [1:0]  cnt2;
        int          cyc;
    } exp_t;

    exp_t sb[$];
    exp_t e;

    int checks = 0;
    int errors = 0;

    logic [31:0] m_y;
    logic        m_hi, m_lo, m_nan, m_ovr;
    int          m_cnt;
    int          last_acc;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    function automatic real fval(input logic [31:0] b);
        int  ex;
        real m, r;
        ex = int'(b[30:23]);
        m  = real'(b[22:0]) / 8388608.0;
        if (ex == 255)     r = 1.0e300;
        else if (ex == 0)  r = m * (2.0 ** (-126));
        else               r = (1.0 + m) * (2.0 ** (ex - 127));
        return b[31] ? -r : r;
    endfunction

    function automatic logic is_nan(input logic [31:0] b);
        return (b[30:23] == 8'hff) && (b[22:0] != 0);
    endfunction

    task automatic model_clear();
        m_y = '0; m_hi = 0; m_lo = 0; m_nan = 0; m_ovr = 0; m_cnt = 0;
        last_acc = -100;
        sb.delete();
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Drives one sta cycle; the model decides from its own step timing whether it is accepted.
    task automatic issue(input logic [31:0] xv);
        exp_t n;
        real  v;
        sta = 1'b1;
        x   = xv;
        if (cyc >= last_acc + 3) begin
            last_acc = cyc;
            if (is_nan(xv)) begin
                m_nan = 1'b1;
            end else begin
                v = fval(xv);
                if (v > fval(YMAX))      begin m_y = YMAX; m_hi = 1; m_lo = 0; end
                else if (v < fval(YMIN)) begin m_y = YMIN; m_hi = 0; m_lo = 1; end
                else begin
                    m_y  = (xv == 32'h80000000) ? 32'h0 : xv;
                    m_hi = 0;
                    m_lo = 0;
                end
                if (m_hi || m_lo) m_cnt++;
            end
            n.y    = m_y;
            n.hi   = m_hi;
            n.lo   = m_lo;
            n.nan  = m_nan;
            n.cnt  = (m_cnt > 65535) ? 16'hffff : 16'(m_cnt);
            n.cnt2 = (m_cnt > 3) ? 2'd3 : 2'(m_cnt);
            n.cyc  = cyc + 3;
            sb.push_back(n);
        end else begin
            m_ovr = 1'b1;
        end
        tick();
        sta = 1'b0;
    endtask

    task automatic step(input logic [31:0] xv);
        int t0;
        t0 = cyc;
        issue(xv);
        while (cyc < t0 + 3) tick();
    endtask

    task automatic check_cleared(input string tag);
        check({tag, "_y"}, y, 0);
        check({tag, "_done"}, done_sig, 0);
        check({tag, "_hi"}, sat_hi, 0);
        check({tag, "_lo"}, sat_lo, 0);
        check({tag, "_nan"}, nan_err, 0);
        check({tag, "_ovr"}, ovr_err, 0);
        check({tag, "_cnt"}, sat_count, 0);
        check({tag, "_cnt2"}, sat_count2, 0);
    endtask

    always @(negedge clk) begin
        if (rst && done_sig) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL spurious_done: done_sig high with no step pending (cycle %0d)", cyc);
            end else begin
                e = sb.pop_front();
                check("latency", 64'(cyc), 64'(e.cyc));
                check("y", y, e.y);
                check("sat_hi", sat_hi, e.hi);
                check("sat_lo", sat_lo, e.lo);
                check("nan_err", nan_err, e.nan);
                check("ovr_err", ovr_err, m_ovr);
                check("sat_count", sat_count, e.cnt);
                check("sat_count_w2", sat_count2, e.cnt2);
                check("done_w2", done2, 1);
            end
        end
    end

    logic [31:0] pool [12] = '{
        32'h3f800000, 32'hbf800000, 32'h80000000, 32'h00000000,
        32'h7f800000, 32'hff800000, 32'h7fc00000, 32'h3f800001,
        32'hbf800001, 32'h3f7fffff, 32'hbf7fffff, 32'h00000001
    };

    initial begin
        int t0;
        int wait_cnt;
        model_clear();
        repeat (3) tick();
        check_cleared("reset");
        rst = 1'b1;
        tick();

        step(32'h3f000000);
        step(32'h40000000);
        step(32'hc0400000);
        step(32'h7f800000);
        step(32'h3f800000);
        step(32'h80000000);
        step(32'h40000000);
        step(32'h7fc00000);

        step(32'h3e800000);
        step(32'hbe800000);

        t0 = cyc;
        issue(32'h40000000);
        issue(32'hc0000000);
        while (cyc < t0 + 3) tick();
        repeat (2) tick();

        t0 = cyc;
        issue(32'h40000000);
        tick();
        rst_user = 1'b1;
        model_clear();
        tick();
        rst_user = 1'b0;
        repeat (3) tick();
        check_cleared("user_reset");

        repeat (5) step(32'hc1000000);
        step(32'h3f000000);

        step(32'h40000000);
        issue(32'hc0400000);
        tick();
        #2;
        rst = 1'b0;
        #1;
        check_cleared("async_reset");
        model_clear();
        @(posedge clk);
        #1;
        rst = 1'b1;
        tick();

        for (int i = 0; i < 60; i++) begin
            logic [31:0] xv;
            xv = ($urandom_range(0, 1) == 0) ? pool[$urandom_range(0, 11)] : $urandom;
            t0 = cyc;
            issue(xv);
            if ($urandom_range(0, 4) == 0) issue($urandom);
            while (cyc < t0 + 3) tick();
            repeat ($urandom_range(0, 2)) tick();
        end

        wait_cnt = 0;
        while (sb.size() != 0 && wait_cnt < 20) begin
            tick();
            wait_cnt++;
        end
        check("pending_steps", 64'(sb.size()), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
